mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM pipeline stage of the RV32I core. Sits between ex_mem and mem_wb and drives mem_wd/mem_wreg/mem_wdata into mem_wb.
//  Executes loads/stores over a req/ack data-memory port: byte-lane steering and load sign/zero extension.
//  Raises stallreq to hold upstream stages while an access is outstanding; mem_wb receives bubbles meanwhile.
// PARAMETERS
//  ACK_TIMEOUT  16  max BUSY cycles without dmem_ack_i before abort; 0 = wait forever
//  TO_CNT_W     8   timeout counter width; must satisfy ACK_TIMEOUT < 2**TO_CNT_W
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, asynchronous, active-low (0 = reset)
//  wd_i          in   5   dest reg addr from ex_mem
//  wreg_i        in   1   dest write enable from ex_mem
//  wdata_i       in   32  ALU result; passed through for non-memory ops
//  memop_i       in   4   0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; other codes = NONE
//  mem_addr_i    in   32  effective byte address
//  mem_sdata_i   in   32  store data (rs2)
//  dmem_req_o    out  1   memory request, held until ack
//  dmem_we_o     out  1   1 = store
//  dmem_addr_o   out  32  word address, {addr[31:2],2'b00}
//  dmem_be_o     out  4   byte enables
//  dmem_wdata_o  out  32  lane-replicated store data
//  dmem_rdata_i  in   32  read word, valid with ack
//  dmem_ack_i    in   1   one-cycle completion strobe
//  mem_wd        out  5   to mem_wb
//  mem_wreg      out  1   to mem_wb
//  mem_wdata     out  32  to mem_wb
//  stallreq      out  1   stall request to pipeline control
//  bus_err_o     out  1   one-cycle pulse on timeout abort
//  misalign_o    out  1   one-cycle pulse on misaligned access (0 when feature off)
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, captured data 0; dmem_req_o/we_o=0, addr/wdata/be=0, bus_err_o=0, misalign_o=0.
//    Outputs mem_wd/mem_wreg/mem_wdata/stallreq follow IDLE combinational rules below.
//  - Reset mid-access: immediate IDLE, req dropped asynchronously; a later ack is ignored.
//  - IDLE, memop NONE: mem_wd=wd_i, mem_wreg=wreg_i, mem_wdata=wdata_i (combinational); stallreq=0.
//  - IDLE, valid memop: stallreq=1, bubble out (mem_wd=0, mem_wreg=0, mem_wdata=0).
//    Register addr/be/wdata/we; next state BUSY.
//  - BUSY: dmem_req_o=1 with stable fields; stallreq=1; bubble out; counter increments each cycle.
//    On dmem_ack_i: capture extended load data (stores capture 0) -> DONE.
//    Counter reaching ACK_TIMEOUT (if nonzero) without ack: drop req, bus_err_o=1 for one cycle -> DONE with mem_wreg forced 0.
//  - DONE: stallreq=0; mem_wd=wd_i, mem_wreg=wreg_i (0 if aborted), mem_wdata=captured data. Next state IDLE unconditionally.
//  - Latency: access occupies >= 3 cycles (IDLE, BUSY x N, DONE); ack in first BUSY cycle gives 3.
//  - dmem_ack_i outside BUSY is ignored.
//  - Lanes, off = addr[1:0]:
//    SB: be = 4'b0001<<off, wdata = {4{sdata[7:0]}}
//    SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{sdata[15:0]}}
//    SW: be = 4'b1111
//    Loads: byte = rdata>>(8*off), half = rdata>>(16*addr[1]); LB/LH sign-extend, LBU/LHU zero-extend.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    Halfword access with addr[0]=1, or word access with addr[1:0]!=0, seen in IDLE: no request;
//    misalign_o=1 for that cycle; stallreq=0; bubble out; stay IDLE.
//  MISALIGN_TRAP_EN undefined: misalign_o tied 0; LW/SW ignore addr[1:0]; LH/LHU/SH ignore addr[0].
// TESTING
//  1. memop=0, wd_i=5, wreg_i=1, wdata_i=32'h1234 -> same cycle mem_wd=5, mem_wreg=1, mem_wdata=32'h1234, stallreq=0.
//  2. LB at addr 32'h103, ack after 2 BUSY cycles with rdata=32'h80FF_FF00 ->
//     stallreq high 3 cycles, then DONE mem_wdata=32'hFFFF_FF80; dmem_addr_o=32'h100.
//  3. SH at addr 32'h202, sdata=32'hxxxx_BEEF, ack in first BUSY cycle ->
//     be=4'b1100, dmem_wdata_o=32'hBEEF_BEEF, we=1, total 3 cycles.
//  4. LW, no ack, ACK_TIMEOUT=16 -> req drops after 16 BUSY cycles, bus_err_o one pulse, DONE mem_wreg=0.
//  5. rst low during BUSY -> dmem_req_o=0 without waiting for clk; a later ack is ignored; state IDLE.
//  6. LW at addr 32'h2, with MISALIGN_TRAP_EN -> misalign_o=1, no req.
//     Without MISALIGN_TRAP_EN -> dmem_addr_o=32'h0, normal load.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: RV32I MEM stage that steers byte lanes over a req/ack data port and extends load data.
// Optional macro MISALIGN_TRAP_EN traps misaligned halfword/word accesses in IDLE instead of issuing them.
module mem_access #(
  parameter int ACK_TIMEOUT = 16,
  parameter int TO_CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stallreq,
  output logic        bus_err_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [3:0]          be_q, be_d, op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic                we_q, we_d, abort_q, abort_d;

  logic        op_valid, is_store, misaligned, timeout;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign op_valid = (memop_i >= OP_LB) && (memop_i <= OP_SW);
  assign timeout  = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = 32'h0;
    is_store   = 1'b0;
    case (memop_i)
      OP_LB, OP_LBU, OP_SB: lane_be = 4'b0001 << mem_addr_i[1:0];
      OP_LH, OP_LHU, OP_SH: lane_be = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:         lane_be = 4'b1111;
      default: ;
    endcase
    case (memop_i)
      OP_SB: begin is_store = 1'b1; lane_wdata = {4{mem_sdata_i[7:0]}};  end
      OP_SH: begin is_store = 1'b1; lane_wdata = {2{mem_sdata_i[15:0]}}; end
      OP_SW: begin is_store = 1'b1; lane_wdata = mem_sdata_i;            end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (memop_i)
      OP_LH, OP_LHU, OP_SH: misaligned = mem_addr_i[0];
      OP_LW, OP_SW:         misaligned = |mem_addr_i[1:0];
      default: ;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Extension uses the offset latched at issue, since ex_mem may not be trusted mid-access.
  assign ld_byte = 8'(dmem_rdata_i >> {off_q, 3'b000});
  assign ld_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    ld_ext = 32'h0;
    case (op_q)
      OP_LB:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LH:  ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LW:  ld_ext = dmem_rdata_i;
      OP_LBU: ld_ext = {24'h0, ld_byte};
      OP_LHU: ld_ext = {16'h0, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    op_d       = op_q;
    off_d      = off_q;
    data_d     = data_q;
    abort_d    = abort_q;
    stallreq   = 1'b0;
    misalign_o = 1'b0;
    mem_wd     = wd_i;
    mem_wreg   = wreg_i;
    mem_wdata  = wdata_i;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          mem_wd    = 5'd0;
          mem_wreg  = 1'b0;
          mem_wdata = 32'h0;
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stallreq = 1'b1;
            addr_d   = {mem_addr_i[31:2], 2'b00};
            be_d     = lane_be;
            wdata_d  = lane_wdata;
            we_d     = is_store;
            op_d     = memop_i;
            off_d    = mem_addr_i[1:0];
            cnt_d    = '0;
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stallreq  = 1'b1;
        mem_wd    = 5'd0;
        mem_wreg  = 1'b0;
        mem_wdata = 32'h0;
        cnt_d     = cnt_q + 1'b1;
        if (dmem_ack_i) begin
          data_d  = we_q ? 32'h0 : ld_ext;
          abort_d = 1'b0;
          state_d = S_DONE;
        end else if (timeout) begin
          data_d  = 32'h0;
          abort_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        mem_wreg  = wreg_i & ~abort_q;
        mem_wdata = data_q;
        abort_d   = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      op_q    <= 4'h0;
      off_q   <= 2'b00;
      data_q  <= 32'h0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      op_q    <= op_d;
      off_q   <= off_d;
      data_q  <= data_d;
      abort_q <= abort_d;
    end
  end

  assign dmem_req_o   = (state_q == S_BUSY);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign bus_err_o    = abort_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table vectors, hand sequences and random transactions for the mem_access MEM stage.
// Built with MISALIGN_TRAP_EN undefined.
module tb_mem_access;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wdI;
  logic        wregI;
  logic [31:0] wdataI;
  logic [3:0]  memopI;
  logic [31:0] addrI, sdataI, rdataI;
  logic        ackI;
  logic        reqO, weO, stallO, busErrO, misalignO, memWregO;
  logic [31:0] dAddrO, dWdataO, memWdataO;
  logic [3:0]  beO;
  logic [4:0]  memWdO;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access #(.ACK_TIMEOUT(TO), .TO_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wd_i(wdI), .wreg_i(wregI), .wdata_i(wdataI),
    .memop_i(memopI), .mem_addr_i(addrI), .mem_sdata_i(sdataI),
    .dmem_req_o(reqO), .dmem_we_o(weO), .dmem_addr_o(dAddrO), .dmem_be_o(beO),
    .dmem_wdata_o(dWdataO), .dmem_rdata_i(rdataI), .dmem_ack_i(ackI),
    .mem_wd(memWdO), .mem_wreg(memWregO), .mem_wdata(memWdataO),
    .stallreq(stallO), .bus_err_o(busErrO), .misalign_o(misalignO)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] expData;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rules written as plain arithmetic on the byte address.
  function automatic logic [31:0] modelLoad(input logic [3:0] op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    h = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      4'd1: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      4'd2: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      4'd3: return rdata;
      4'd4: return b;
      4'd5: return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] modelBe(input logic [3:0] op, input logic [31:0] addr);
    case (op)
      4'd6: return 4'(1 << addr[1:0]);
      4'd7: return addr[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input logic [3:0] op, input logic [31:0] sdata);
    case (op)
      4'd6: return (sdata & 32'hFF) * 32'h0101_0101;
      4'd7: return (sdata & 32'hFFFF) * 32'h0001_0001;
      default: return sdata;
    endcase
  endfunction

  task automatic checkPass(input string tag, input logic [3:0] op, input logic [4:0] wd,
                           input logic wreg, input logic [31:0] wdata);
    @(posedge clk); #1;
    memopI = op; wdI = wd; wregI = wreg; wdataI = wdata; ackI = 1'b0;
    @(negedge clk);
    checkOutput({tag, " pass mem_wd"}, 32'(memWdO), 32'(wd));
    checkOutput({tag, " pass mem_wreg"}, 32'(memWregO), 32'(wreg));
    checkOutput({tag, " pass mem_wdata"}, memWdataO, wdata);
    checkOutput({tag, " pass stallreq"}, 32'(stallO), 32'h0);
  endtask

  // One full access: IDLE issue, BUSY cycles until ack or timeout, then DONE.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] rdata, input int ackDelay,
                               input logic [4:0] wd, input logic wreg, input logic [31:0] expData,
                               input logic [3:0] expBe, input logic [31:0] expWdata);
    bit store, tOut;
    int busy;
    store = (op >= 4'd6) && (op <= 4'd8);
    tOut  = (ackDelay > TO);
    busy  = tOut ? TO : ackDelay;
    @(posedge clk); #1;
    memopI = op; addrI = addr; sdataI = sdata; wdI = wd; wregI = wreg; wdataI = 32'h5A5A_5A5A;
    @(negedge clk);
    checkOutput({tag, " idle stallreq"}, 32'(stallO), 32'h1);
    checkOutput({tag, " idle bubble"}, {memWdataO[31:6], memWregO, memWdO}, 32'h0);
    checkOutput({tag, " idle req"}, 32'(reqO), 32'h0);
    for (int k = 1; k <= busy; k++) begin
      @(posedge clk); #1;
      ackI   = (k == ackDelay);
      rdataI = (k == ackDelay) ? rdata : $urandom;
      @(negedge clk);
      checkOutput({tag, " busy req"}, 32'(reqO), 32'h1);
      checkOutput({tag, " busy stallreq"}, 32'(stallO), 32'h1);
      checkOutput({tag, " busy mem_wreg"}, 32'(memWregO), 32'h0);
      checkOutput({tag, " busy bus_err"}, 32'(busErrO), 32'h0);
      checkOutput({tag, " busy addr"}, dAddrO, addr & 32'hFFFF_FFFC);
      checkOutput({tag, " busy we"}, 32'(weO), 32'(store));
      if (store) begin
        checkOutput({tag, " busy be"}, 32'(beO), 32'(expBe));
        checkOutput({tag, " busy wdata"}, dWdataO, expWdata);
      end
    end
    @(posedge clk); #1;
    ackI = 1'b0;
    @(negedge clk);
    checkOutput({tag, " done stallreq"}, 32'(stallO), 32'h0);
    checkOutput({tag, " done req"}, 32'(reqO), 32'h0);
    checkOutput({tag, " done mem_wd"}, 32'(memWdO), 32'(wd));
    checkOutput({tag, " done mem_wreg"}, 32'(memWregO), tOut ? 32'h0 : 32'(wreg));
    checkOutput({tag, " done mem_wdata"}, memWdataO, tOut ? 32'h0 : expData);
    checkOutput({tag, " done bus_err"}, 32'(busErrO), 32'(tOut));
    @(posedge clk); #1;
    memopI = 4'd0;
    @(negedge clk);
    checkOutput({tag, " after bus_err"}, 32'(busErrO), 32'h0);
    checkOutput({tag, " after stallreq"}, 32'(stallO), 32'h0);
  endtask

  initial begin
    rst = 1'b0; memopI = 4'd0; wdI = 5'd5; wregI = 1'b1; wdataI = 32'h1234;
    addrI = 32'h0; sdataI = 32'h0; rdataI = 32'h0; ackI = 1'b0;

    #2;
    checkOutput("reset req", 32'(reqO), 32'h0);
    checkOutput("reset we", 32'(weO), 32'h0);
    checkOutput("reset addr", dAddrO, 32'h0);
    checkOutput("reset be", 32'(beO), 32'h0);
    checkOutput("reset wdata", dWdataO, 32'h0);
    checkOutput("reset bus_err", 32'(busErrO), 32'h0);
    checkOutput("reset misalign", 32'(misalignO), 32'h0);
    checkOutput("reset pass mem_wd", 32'(memWdO), 32'h5);
    checkOutput("reset pass mem_wdata", memWdataO, 32'h1234);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    checkPass("t1", 4'd0, 5'd5, 1'b1, 32'h1234);
    checkPass("badop", 4'hB, 5'd17, 1'b1, 32'hA5A5_0F0F);

    vecs[0] = '{4'd1, 32'h103, 32'h0, 32'h80FF_FF00, 2, 32'hFFFF_FF80, 4'h8, 32'h0};
    vecs[1] = '{4'd7, 32'h202, 32'h1234_BEEF, 32'h0, 1, 32'h0, 4'hC, 32'hBEEF_BEEF};
    vecs[2] = '{4'd3, 32'h2, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[3] = '{4'd4, 32'h101, 32'h0, 32'h1234_8056, 1, 32'h0000_0080, 4'h2, 32'h0};
    vecs[4] = '{4'd2, 32'h10, 32'h0, 32'h0000_8001, 2, 32'hFFFF_8001, 4'h3, 32'h0};
    vecs[5] = '{4'd5, 32'h12, 32'h0, 32'hF00D_0001, 1, 32'h0000_F00D, 4'hC, 32'h0};
    vecs[6] = '{4'd6, 32'h301, 32'h0000_00AB, 32'h0, 1, 32'h0, 4'h2, 32'hABAB_ABAB};
    vecs[7] = '{4'd8, 32'h400, 32'hCAFE_F00D, 32'h0, 3, 32'h0, 4'hF, 32'hCAFE_F00D};
    vecs[8] = '{4'd2, 32'h13, 32'h0, 32'h7FFF_0000, 1, 32'h0000_7FFF, 4'hC, 32'h0};
    vecs[9] = '{4'd1, 32'h100, 32'h0, 32'h0000_007F, 3, 32'h0000_007F, 4'h1, 32'h0};
    for (int i = 0; i < 10; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rdata,
                    vecs[i].delay, 5'(i + 1), 1'b1, vecs[i].expData, vecs[i].expBe, vecs[i].expWdata);

    // No ack at all: the access aborts after TO busy cycles.
    applyStimulus("timeout", 4'd3, 32'h500, 32'h0, 32'h0, 100, 5'd3, 1'b1, 32'h0, 4'hF, 32'h0);

    // Reset dropped mid-access must kill the request without a clock edge.
    @(posedge clk); #1;
    memopI = 4'd3; addrI = 32'h40; wdI = 5'd7; wregI = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstmid req before", 32'(reqO), 32'h1);
    #2;
    memopI = 4'd0; rst = 1'b0;
    #1;
    checkOutput("rstmid req async", 32'(reqO), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; ackI = 1'b1; rdataI = 32'hFFFF_FFFF; wdI = 5'd9; wregI = 1'b1; wdataI = 32'hABC;
    @(negedge clk);
    checkOutput("rstmid stray ack stallreq", 32'(stallO), 32'h0);
    checkOutput("rstmid stray ack mem_wdata", memWdataO, 32'hABC);
    @(posedge clk); #1;
    ackI = 1'b0;
    @(negedge clk);
    checkOutput("rstmid idle req", 32'(reqO), 32'h0);
    checkOutput("rstmid idle mem_wd", 32'(memWdO), 32'd9);
    checkOutput("rstmid idle mem_wdata", memWdataO, 32'hABC);

    // Random transactions against the reference rules.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [31:0] a, s, r;
      if ($urandom_range(0, 3) == 0) begin
        op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
        checkPass($sformatf("rnd%0d", n), op, 5'($urandom), 1'($urandom), $urandom);
      end else begin
        op = 4'($urandom_range(1, 8));
        a = $urandom; s = $urandom; r = $urandom;
        applyStimulus($sformatf("rnd%0d", n), op, a, s, r, $urandom_range(1, 5), 5'($urandom),
                      1'($urandom), modelLoad(op, a, r), modelBe(op, a), modelWdata(op, s));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
